instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the main controller. Holds the PC, fetches
//  32-bit words from instruction memory over a req/ack handshake, and presents them on
//  `instruction` with a valid/ready handshake to decode/control.
//  Consumes the controller's taken-branch result (Branch, already ANDed with Zero) plus a
//  target address, and redirects the PC.
//  Wrong-path fetches in flight are discarded.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//  NOP_INSTR 32'h0000_0013  value driven on `instruction` after reset (addi x0,x0,0)
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  word-aligned fetch address, valid while imem_req=1
//  imem_ack       in   1   memory response strobe; imem_rdata valid in same cycle
//  imem_rdata     in   32  fetched word
//  instruction    out  32  instruction presented to the controller
//  inst_valid     out  1   `instruction`/pc_out hold a valid, right-path instruction
//  inst_ready     in   1   consumer accepts instruction when inst_valid & inst_ready
//  pc_out         out  32  PC of the presented instruction
//  branch_taken   in   1   redirect request (controller Branch output)
//  branch_target  in   32  redirect address; bits [1:0] ignored and forced to 0
// BEHAVIOUR
//  All outputs registered.
//  Reset (rst=1 at edge): pc<=RESET_PC, state<=IDLE, imem_req<=0, imem_addr<=RESET_PC,
//    inst_valid<=0, instruction<=NOP_INSTR, pc_out<=RESET_PC.
//    imem_ack during reset ignored.
//    Reset mid-request abandons the request; the memory is reset with the same rst.
//  FSM states: IDLE, REQ, HOLD, DISCARD.
//  IDLE: next edge -> REQ with imem_req<=1, imem_addr<=pc. First request is one cycle after rst falls.
//  REQ: imem_req and imem_addr held stable until imem_ack.
//    On ack (no redirect): instruction<=imem_rdata, pc_out<=pc, inst_valid<=1,
//      pc<=pc+4, imem_req<=0, -> HOLD.
//    Latency: ack at edge N -> inst_valid=1 after edge N.
//  HOLD: instruction, pc_out and inst_valid stable while inst_ready=0; no request issued.
//    On valid&ready: inst_valid<=0, imem_req<=1, imem_addr<=pc, -> REQ.
//    Throughput: 1 instruction / 2 cycles with zero-wait memory.
//  Redirect (branch_taken=1, state!=IDLE) has priority over all other events.
//    Every case sets pc<={branch_target[31:2],2'b00}.
//    - HOLD: inst_valid<=0 (held word dropped even if inst_ready=1 same cycle);
//      issue req to target, -> REQ.
//    - REQ with imem_ack same cycle: rdata dropped; imem_req<=1, imem_addr<=target, -> REQ.
//    - REQ without ack: request must complete.
//      Keep imem_req/old imem_addr, -> DISCARD.
//    - DISCARD: on ack, data dropped; imem_req<=1, imem_addr<=pc, -> REQ.
//      A further redirect in DISCARD only updates pc (last target wins).
//  inst_valid is never 1 for a wrong-path word.
//  PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//  imem_ack outside REQ/DISCARD is a protocol error: ignored, no state change.
// TESTING
//  1 Reset: rst=1 for 2 cycles, then 0 -> req=0, valid=0, instruction=32'h13;
//    imem_req=1 with addr 0 one cycle after release.
//  2 Stream: zero-wait ack, inst_ready=1; mem[0]=A, [4]=B, [8]=C
//    -> presented A/B/C with pc_out 0/4/8, one every 2 cycles.
//  3 Backpressure: inst_ready=0 for 5 cycles while valid
//    -> instruction and pc_out unchanged, imem_req=0 throughout.
//  4 Redirect in flight: ack delayed 3 cycles, branch_taken with target 0x40 on first req cycle
//    -> returned word never valid; next req addr 0x40.
//  5 Redirect in HOLD with target 0x103 and inst_ready=1 same cycle
//    -> held word dropped, next imem_addr=0x100.
//  6 Wrap and collision:
//    - RESET_PC=32'hFFFF_FFFC -> second fetch addr 0x0.
//    - ack and branch_taken same cycle -> data dropped, req to target next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : PC + req/ack instruction fetch with valid/ready output and
//           branch redirect that drops wrong-path words.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc_out,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [31:0] r_pc,     w_pc_nxt;
    logic [31:0] r_addr,   w_addr_nxt;
    logic [31:0] r_instr,  w_instr_nxt;
    logic [31:0] r_pc_out, w_pc_out_nxt;
    logic        r_req,    w_req_nxt;
    logic        r_valid,  w_valid_nxt;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_target = branch_target & ~32'd3;
    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_pc_out <= RESET_PC;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_addr   <= w_addr_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_req    <= w_req_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_addr_nxt   = r_addr;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        w_req_nxt    = r_req;
        w_valid_nxt  = r_valid;

        case (r_state)
            S_IDLE: begin
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_pc;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (branch_taken) begin
                    w_pc_nxt = w_target;
                    if (imem_ack) begin
                        w_addr_nxt  = w_target;
                        w_state_nxt = S_REQ;
                    end else begin
                        // Outstanding request cannot be withdrawn; drain it first.
                        w_state_nxt = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt  = imem_rdata;
                    w_pc_out_nxt = r_pc;
                    w_valid_nxt  = 1'b1;
                    w_pc_nxt     = w_pc_inc;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_target;
                    w_state_nxt = S_REQ;
                end else if (inst_ready) begin
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                if (branch_taken) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = branch_taken ? w_target : r_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_instr;
    assign inst_valid  = r_valid;
    assign pc_out      = r_pc_out;

endmodule
`default_nettype wire
